// File: rtl/axi_lite_mmio_regs.sv
// AXI4-Lite MMIO register bank: NUM_REGS 32-bit slots, slot 0 is the read-only status word.
// Optional AXI_PROT_CHECK_EN: unprivileged (prot[0]=0) accesses get SLVERR.
module axi_lite_mmio_regs #(
  parameter int          NUM_REGS  = 8,
  parameter int          ADDR_W    = 20,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  arest,
  input  logic [ADDR_W-1:0]     S_AXI_awaddr,
  input  logic [2:0]            S_AXI_awprot,
  input  logic                  S_AXI_awvalid,
  output logic                  S_AXI_awready,
  input  logic [31:0]           S_AXI_wdata,
  input  logic [3:0]            S_AXI_wstrb,
  input  logic                  S_AXI_wvalid,
  output logic                  S_AXI_wready,
  output logic [1:0]            S_AXI_bresp,
  output logic                  S_AXI_bvalid,
  input  logic                  S_AXI_bready,
  input  logic [ADDR_W-1:0]     S_AXI_araddr,
  input  logic [2:0]            S_AXI_arprot,
  input  logic                  S_AXI_arvalid,
  output logic                  S_AXI_arready,
  output logic [31:0]           S_AXI_rdata,
  output logic [1:0]            S_AXI_rresp,
  output logic                  S_AXI_rvalid,
  input  logic                  S_AXI_rready,
  input  logic [31:0]           status_i,
  output logic [NUM_REGS*32-1:0] regs_o,
  output logic [NUM_REGS-1:0]   wr_stb_o
);
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_RESP } r_state_e;

  w_state_e             w_state_q, w_state_d;
  r_state_e             r_state_q, r_state_d;
  logic                 aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                 aw_priv_q, aw_priv_d;
  logic [IDX_W-1:0]     aw_idx_q, aw_idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [1:0]           bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [NUM_REGS-1:0]  wr_stb_q, wr_stb_d;
  logic [31:0]          regs_q [NUM_REGS];
  logic [31:0]          regs_d [NUM_REGS];
  logic [IDX_W-1:0]     ar_idx;
  logic                 aw_priv_in, ar_priv;
  logic                 unused_bits;

  assign ar_idx = S_AXI_araddr[ADDR_W-1:2];
`ifdef AXI_PROT_CHECK_EN
  assign aw_priv_in = S_AXI_awprot[0];
  assign ar_priv    = S_AXI_arprot[0];
`else
  assign aw_priv_in = 1'b1;
  assign ar_priv    = 1'b1;
`endif
  assign unused_bits = ^{S_AXI_awaddr[1:0], S_AXI_araddr[1:0], S_AXI_awprot, S_AXI_arprot};

  // DECERR outranks SLVERR; priv is tied high when prot checking is compiled out.
  function automatic logic [1:0] decode(input logic [IDX_W-1:0] idx, input logic is_wr,
                                        input logic priv);
    logic [1:0] resp;
    resp = RESP_OKAY;
    if (idx >= IDX_W'(NUM_REGS))   resp = RESP_DECERR;
    else if (is_wr && idx == '0)   resp = RESP_SLVERR;
    else if (!priv)                resp = RESP_SLVERR;
    return resp;
  endfunction

  always_comb begin
    w_state_d     = w_state_q;
    aw_held_d     = aw_held_q;
    aw_priv_d     = aw_priv_q;
    aw_idx_d      = aw_idx_q;
    w_held_d      = w_held_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    bresp_d       = bresp_q;
    wr_stb_d      = '0;
    regs_d        = regs_q;
    S_AXI_awready = 1'b0;
    S_AXI_wready  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        S_AXI_awready = !aw_held_q && !arest;
        S_AXI_wready  = !w_held_q && !arest;
        if (aw_held_q && w_held_q) begin
          bresp_d   = decode(aw_idx_q, 1'b1, aw_priv_q);
          w_state_d = W_RESP;
          if (bresp_d == RESP_OKAY) begin
            for (int k = 1; k < NUM_REGS; k++) begin
              if (aw_idx_q == IDX_W'(k)) begin
                for (int b = 0; b < 4; b++)
                  if (wstrb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                wr_stb_d[k] = 1'b1;
              end
            end
          end
        end else begin
          if (S_AXI_awready && S_AXI_awvalid) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_awaddr[ADDR_W-1:2];
            aw_priv_d = aw_priv_in;
          end
          if (S_AXI_wready && S_AXI_wvalid) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_wdata;
            wstrb_d  = S_AXI_wstrb;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read samples regs_q, so a read on the commit edge sees the pre-write value.
  always_comb begin
    r_state_d     = r_state_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    S_AXI_arready = (r_state_q == R_IDLE) && !arest;
    case (r_state_q)
      R_IDLE: begin
        if (S_AXI_arready && S_AXI_arvalid) begin
          rresp_d   = decode(ar_idx, 1'b0, ar_priv);
          rdata_d   = '0;
          r_state_d = R_RESP;
          if (rresp_d == RESP_OKAY) begin
            if (ar_idx == '0) rdata_d = status_i;
            for (int k = 1; k < NUM_REGS; k++)
              if (ar_idx == IDX_W'(k)) rdata_d = regs_q[k];
          end
        end
      end
      R_RESP: if (S_AXI_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arest) begin
    if (arest) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      aw_priv_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      wr_stb_q  <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= (k == 0) ? 32'h0 : RESET_VAL;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      aw_priv_q <= aw_priv_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      wr_stb_q  <= wr_stb_d;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  assign S_AXI_bvalid = (w_state_q == W_RESP);
  assign S_AXI_bresp  = bresp_q;
  assign S_AXI_rvalid = (r_state_q == R_RESP);
  assign S_AXI_rresp  = rresp_q;
  assign S_AXI_rdata  = rdata_q;
  assign wr_stb_o     = wr_stb_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_axi_lite_mmio_regs.sv
// Bench for axi_lite_mmio_regs: B/R responses checked against expectation queues by monitors.
module tb_axi_lite_mmio_regs;
  localparam int NR = 8;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic arest;
  logic [AW-1:0] S_AXI_awaddr, S_AXI_araddr;
  logic [2:0]    S_AXI_awprot, S_AXI_arprot;
  logic          S_AXI_awvalid, S_AXI_awready, S_AXI_wvalid, S_AXI_wready;
  logic [31:0]   S_AXI_wdata, S_AXI_rdata, status_i;
  logic [3:0]    S_AXI_wstrb;
  logic [1:0]    S_AXI_bresp, S_AXI_rresp;
  logic          S_AXI_bvalid, S_AXI_bready, S_AXI_arvalid, S_AXI_arready;
  logic          S_AXI_rvalid, S_AXI_rready;
  logic [NR*32-1:0] regs_o;
  logic [NR-1:0]    wr_stb_o;

  axi_lite_mmio_regs #(.NUM_REGS(NR), .ADDR_W(AW), .RESET_VAL(32'h0)) dut (
    .clk(clk), .arest(arest),
    .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot), .S_AXI_awvalid(S_AXI_awvalid),
    .S_AXI_awready(S_AXI_awready), .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb),
    .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready), .S_AXI_bresp(S_AXI_bresp),
    .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready), .S_AXI_araddr(S_AXI_araddr),
    .S_AXI_arprot(S_AXI_arprot), .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
    .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp), .S_AXI_rvalid(S_AXI_rvalid),
    .S_AXI_rready(S_AXI_rready), .status_i(status_i), .regs_o(regs_o), .wr_stb_o(wr_stb_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  typedef struct packed { logic [1:0] resp; logic [31:0] data; } rexp_t;
  logic [1:0]  exp_b [$];
  rexp_t       exp_r [$];
  logic [1:0]  bexp;
  rexp_t       rexp;
  logic [31:0] model [NR];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  function automatic logic [NR*32-1:0] model_packed();
    logic [NR*32-1:0] p;
    for (int k = 0; k < NR; k++) p[32*k +: 32] = model[k];
    return p;
  endfunction

  // Scoreboard monitors: pop one expectation per completed B / R handshake.
  always @(negedge clk) begin
    if (!arest && S_AXI_bvalid && S_AXI_bready) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: bresp=%b with no response expected", S_AXI_bresp);
      end else begin
        bexp = exp_b.pop_front();
        if (S_AXI_bresp !== bexp) begin
          errors++;
          $display("FAIL bresp: got %b expected %b", S_AXI_bresp, bexp);
        end
      end
    end
    if (!arest && S_AXI_rvalid && S_AXI_rready) begin
      checks++;
      if (exp_r.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected: rresp=%b rdata=%h with no response expected",
                 S_AXI_rresp, S_AXI_rdata);
      end else begin
        rexp = exp_r.pop_front();
        if (S_AXI_rresp !== rexp.resp || S_AXI_rdata !== rexp.data) begin
          errors++;
          $display("FAIL rresp_rdata: got %b/%h expected %b/%h",
                   S_AXI_rresp, S_AXI_rdata, rexp.resp, rexp.data);
        end
      end
    end
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] prot,
                           input logic do_aw, input logic do_w);
    logic a, w;
    S_AXI_awaddr = addr; S_AXI_awprot = prot; S_AXI_wdata = data; S_AXI_wstrb = strb;
    S_AXI_awvalid = do_aw; S_AXI_wvalid = do_w;
    for (int i = 0; i < 20 && (S_AXI_awvalid || S_AXI_wvalid); i++) begin
      @(negedge clk);
      a = S_AXI_awvalid && S_AXI_awready;
      w = S_AXI_wvalid && S_AXI_wready;
      @(posedge clk); #1;
      if (a) S_AXI_awvalid = 1'b0;
      if (w) S_AXI_wvalid = 1'b0;
    end
    if (S_AXI_awvalid || S_AXI_wvalid) begin
      checks++; errors++;
      $display("FAIL write_handshake_timeout: addr=%h awvalid=%b wvalid=%b still pending",
               addr, S_AXI_awvalid, S_AXI_wvalid);
      S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [2:0] prot);
    logic a;
    S_AXI_araddr = addr; S_AXI_arprot = prot; S_AXI_arvalid = 1'b1;
    for (int i = 0; i < 20 && S_AXI_arvalid; i++) begin
      @(negedge clk);
      a = S_AXI_arready;
      @(posedge clk); #1;
      if (a) S_AXI_arvalid = 1'b0;
    end
    if (S_AXI_arvalid) begin
      checks++; errors++;
      $display("FAIL read_handshake_timeout: addr=%h arvalid still pending", addr);
      S_AXI_arvalid = 1'b0;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({S_AXI_awready, S_AXI_wready, S_AXI_arready, S_AXI_bvalid, S_AXI_rvalid} !== 5'b0 ||
        wr_stb_o !== '0 || S_AXI_bresp !== 2'b0 || S_AXI_rresp !== 2'b0 || S_AXI_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/vld=%b stb=%b bresp=%b rresp=%b rdata=%h expected all 0",
               {S_AXI_awready, S_AXI_wready, S_AXI_arready, S_AXI_bvalid, S_AXI_rvalid},
               wr_stb_o, S_AXI_bresp, S_AXI_rresp, S_AXI_rdata);
    end
    checks++;
    if (regs_o !== model_packed()) begin
      errors++; $display("FAIL reset_regs: got %h expected %h", regs_o, model_packed());
    end
    @(posedge clk); #1; arest = 1'b0;
    @(negedge clk);
    checks++;
    if ({S_AXI_awready, S_AXI_wready, S_AXI_arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_reset: got %b expected 111",
                         {S_AXI_awready, S_AXI_wready, S_AXI_arready});
    end
    settle(1);
  endtask

  task automatic test_write_same_cycle();
    exp_b.push_back(2'b00);
    model[1] = merge(model[1], 32'hDEAD_BEEF, 4'hF);
    axi_write(20'h04, 32'hDEAD_BEEF, 4'hF, 3'b001, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (S_AXI_bvalid !== 1'b0) begin
      errors++; $display("FAIL b_latency_early: bvalid=%b expected 0", S_AXI_bvalid);
    end
    @(negedge clk);
    checks++;
    if (S_AXI_bvalid !== 1'b1 || wr_stb_o !== 8'b0000_0010 || regs_o[63:32] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_commit: bvalid=%b stb=%b reg1=%h expected 1/00000010/deadbeef",
               S_AXI_bvalid, wr_stb_o, regs_o[63:32]);
    end
    @(negedge clk);
    checks++;
    if (wr_stb_o !== '0) begin
      errors++; $display("FAIL stb_one_cycle: stb=%b expected 0", wr_stb_o);
    end
    settle(1);
  endtask

  task automatic test_w_before_aw();
    logic ok;
    exp_b.push_back(2'b00);
    model[2] = 32'hFFFF_FFFF;
    axi_write(20'h08, 32'hFFFF_FFFF, 4'hF, 3'b001, 1'b1, 1'b1);
    settle(3);
    exp_b.push_back(2'b00);
    model[2] = merge(model[2], 32'h1234_5678, 4'b0101);
    axi_write(20'h08, 32'h1234_5678, 4'b0101, 3'b001, 1'b0, 1'b1);
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (S_AXI_awready !== 1'b1 || S_AXI_wready !== 1'b0 || S_AXI_bvalid !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL w_held_wait: awready=%b wready=%b bvalid=%b expected 1/0/0",
                         S_AXI_awready, S_AXI_wready, S_AXI_bvalid);
    end
    @(posedge clk); #1;
    axi_write(20'h08, 32'h0, 4'h0, 3'b001, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (S_AXI_bvalid !== 1'b0) begin
      errors++; $display("FAIL aw_late_latency: bvalid=%b expected 0", S_AXI_bvalid);
    end
    @(negedge clk);
    checks++;
    if (S_AXI_bvalid !== 1'b1 || regs_o[95:64] !== 32'hFF34_FF78 || wr_stb_o !== 8'b0000_0100) begin
      errors++; $display("FAIL w_before_aw: bvalid=%b reg2=%h stb=%b expected 1/ff34ff78/00000100",
                         S_AXI_bvalid, regs_o[95:64], wr_stb_o);
    end
    settle(2);
  endtask

  task automatic test_status_slot0();
    logic ok;
    logic stb_seen;
    status_i = 32'hA5A5_0001;
    exp_r.push_back('{resp: 2'b00, data: 32'hA5A5_0001});
    S_AXI_rready = 1'b0;
    axi_read(20'h00, 3'b001);
    status_i = 32'h0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (S_AXI_rvalid !== 1'b1 || S_AXI_rdata !== 32'hA5A5_0001 || S_AXI_rresp !== 2'b00 ||
          S_AXI_arready !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL r_hold: rvalid=%b rdata=%h rresp=%b arready=%b expected 1/a5a50001/00/0",
                         S_AXI_rvalid, S_AXI_rdata, S_AXI_rresp, S_AXI_arready);
    end
    @(posedge clk); #1; S_AXI_rready = 1'b1;
    settle(2);
    exp_b.push_back(2'b10);
    axi_write(20'h00, 32'hFFFF_FFFF, 4'hF, 3'b001, 1'b1, 1'b1);
    stb_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wr_stb_o !== '0) stb_seen = 1'b1;
    end
    checks++;
    if (stb_seen || regs_o !== model_packed()) begin
      errors++; $display("FAIL slot0_write: strobe_seen=%b regs=%h expected no strobe/%h",
                         stb_seen, regs_o, model_packed());
    end
    settle(1);
  endtask

  task automatic test_decerr();
    logic stb_seen;
    exp_r.push_back('{resp: 2'b11, data: 32'h0});
    axi_read(20'h20, 3'b001);
    settle(2);
    exp_b.push_back(2'b11);
    axi_write(20'h40, 32'h1357_9BDF, 4'hF, 3'b001, 1'b1, 1'b1);
    stb_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wr_stb_o !== '0) stb_seen = 1'b1;
    end
    checks++;
    if (stb_seen || regs_o !== model_packed()) begin
      errors++; $display("FAIL decerr_write: strobe_seen=%b regs=%h expected no strobe/%h",
                         stb_seen, regs_o, model_packed());
    end
    settle(1);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a [3] = '{20'h04, 20'h08, 20'h0C};
    logic [31:0]   d [3] = '{32'hCAFE_0001, 32'h0BAD_F00D, 32'h5A5A_5A5A};
    logic [3:0]    s [3] = '{4'hF, 4'b1100, 4'b0011};
    time t [3];
    for (int i = 0; i < 3; i++) begin
      exp_b.push_back(2'b00);
      model[i+1] = merge(model[i+1], d[i], s[i]);
      axi_write(a[i], d[i], s[i], 3'b001, 1'b1, 1'b1);
      t[i] = $time;
    end
    settle(3);
    checks++;
    if ((t[1] - t[0]) !== 30 || (t[2] - t[1]) !== 30) begin
      errors++; $display("FAIL b2b_spacing: got %0t/%0t expected 30/30", t[1]-t[0], t[2]-t[1]);
    end
    checks++;
    if (regs_o !== model_packed()) begin
      errors++; $display("FAIL b2b_regs: got %h expected %h", regs_o, model_packed());
    end
  endtask

  task automatic test_collision();
    exp_b.push_back(2'b00);
    exp_r.push_back('{resp: 2'b00, data: model[2]});
    model[2] = merge(model[2], 32'h7777_7777, 4'hF);
    axi_write(20'h08, 32'h7777_7777, 4'hF, 3'b001, 1'b1, 1'b1);
    axi_read(20'h08, 3'b001);
    settle(2);
    exp_r.push_back('{resp: 2'b00, data: model[2]});
    axi_read(20'h0A, 3'b001);
    settle(2);
    checks++;
    if (regs_o[95:64] !== model[2]) begin
      errors++; $display("FAIL collision_reg: got %h expected %h", regs_o[95:64], model[2]);
    end
  endtask

  task automatic test_prot();
`ifdef AXI_PROT_CHECK_EN
    exp_b.push_back(2'b10);
    axi_write(20'h04, 32'h1111_1111, 4'hF, 3'b000, 1'b1, 1'b1);
    settle(3);
    checks++;
    if (regs_o !== model_packed()) begin
      errors++; $display("FAIL prot_unpriv_write: regs=%h expected %h", regs_o, model_packed());
    end
    exp_r.push_back('{resp: 2'b10, data: 32'h0});
    axi_read(20'h04, 3'b000);
    settle(2);
`endif
    exp_b.push_back(2'b00);
    model[1] = merge(model[1], 32'h2222_2222, 4'hF);
    axi_write(20'h04, 32'h2222_2222, 4'hF, 3'b001, 1'b1, 1'b1);
    settle(3);
    checks++;
    if (regs_o[63:32] !== model[1]) begin
      errors++; $display("FAIL prot_priv_write: reg1=%h expected %h", regs_o[63:32], model[1]);
    end
  endtask

  task automatic test_bready_hold_reset();
    logic ok;
    S_AXI_bready = 1'b0;
    axi_write(20'h0C, 32'h1122_3344, 4'hF, 3'b001, 1'b1, 1'b1);
    @(negedge clk);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (S_AXI_bvalid !== 1'b1 || S_AXI_bresp !== 2'b00 || S_AXI_awready !== 1'b0 ||
          S_AXI_wready !== 1'b0 || regs_o[127:96] !== 32'h1122_3344) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b_hold: bvalid=%b bresp=%b awready=%b wready=%b reg3=%h expected 1/00/0/0/11223344",
                         S_AXI_bvalid, S_AXI_bresp, S_AXI_awready, S_AXI_wready, regs_o[127:96]);
    end
    @(posedge clk); #2;
    arest = 1'b1;
    for (int k = 0; k < NR; k++) model[k] = 32'h0;
    #1;
    checks++;
    if (S_AXI_bvalid !== 1'b0 || regs_o !== model_packed()) begin
      errors++; $display("FAIL async_reset: bvalid=%b regs=%h expected 0/%h",
                         S_AXI_bvalid, regs_o, model_packed());
    end
    settle(2);
    arest = 1'b0;
    S_AXI_bready = 1'b1;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (S_AXI_bvalid !== 1'b0 || S_AXI_awready !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL post_reset_idle: bvalid=%b awready=%b expected 0/1",
                         S_AXI_bvalid, S_AXI_awready);
    end
    settle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    arest = 1'b1;
    S_AXI_awaddr = '0; S_AXI_awprot = '0; S_AXI_awvalid = 1'b0;
    S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wvalid = 1'b0; S_AXI_bready = 1'b1;
    S_AXI_araddr = '0; S_AXI_arprot = '0; S_AXI_arvalid = 1'b0; S_AXI_rready = 1'b1;
    status_i = '0;
    for (int k = 0; k < NR; k++) model[k] = 32'h0;
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_status_slot0();
    test_decerr();
    test_back_to_back();
    test_collision();
    test_prot();
    test_bready_hold_reset();
    settle(2);
    checks++;
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d B and %0d R expectations left, expected 0/0",
                         exp_b.size(), exp_r.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
